// File: rtl/i2c_tx_controller.sv
// Byte-level I2C transmit controller: shifts a programmed number of bytes MSB-first
// on SCL falling-edge strobes and samples the receiver's ACK on the following rising strobe.
module i2c_tx_controller #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StartTX,
    input  logic [CNT_W-1:0]  TXcount,
    input  logic [DATA_W-1:0] TXData,
    input  logic              LoadTXD,
    input  logic              SclFall,
    input  logic              SclRise,
    input  logic              SDAIn,
    output logic              SDAOut,
    output logic              SDAOe,
    output logic              TXReady,
    output logic              ClkHold,
    output logic              ByteDone,
    output logic              TXDone,
    output logic              NackErr
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_ACK_WAIT = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_hold;
    logic              r_holdFull;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_sdaOut;
    logic              r_sdaOe;
    logic              r_byteDone;
    logic              r_txDone;
    logic              r_nackErr;

    logic w_loadAccept;
    logic w_moveToShift;

    assign w_loadAccept  = LoadTXD && !r_holdFull;
    assign w_moveToShift = (r_state == S_LOAD) && r_holdFull && StartTX;

    assign SDAOut   = r_sdaOut;
    assign SDAOe    = r_sdaOe;
    assign TXReady  = !r_holdFull;
    assign ClkHold  = (r_state == S_LOAD) && !r_holdFull && StartTX;
    assign ByteDone = r_byteDone;
    assign TXDone   = r_txDone;
    assign NackErr  = r_nackErr;

    // Holding register survives aborts so a byte loaded ahead is sent on the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold     <= '0;
            r_holdFull <= 1'b0;
        end else if (w_moveToShift) begin
            r_holdFull <= 1'b0;
        end else if (w_loadAccept) begin
            r_hold     <= TXData;
            r_holdFull <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_remaining <= '0;
            r_sdaOut    <= 1'b1;
            r_sdaOe     <= 1'b0;
            r_byteDone  <= 1'b0;
            r_txDone    <= 1'b0;
            r_nackErr   <= 1'b0;
        end else begin
            r_byteDone <= 1'b0;
            r_txDone   <= 1'b0;
            // Dropping StartTX outside IDLE both aborts a transfer and leaves DONE.
            if (!StartTX && (r_state != S_IDLE)) begin
                r_state  <= S_IDLE;
                r_sdaOe  <= 1'b0;
                r_sdaOut <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_sdaOe <= 1'b0;
                        if (StartTX && (TXcount != '0)) begin
                            r_remaining <= TXcount;
                            r_nackErr   <= 1'b0;
                            r_state     <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (r_holdFull) begin
                            r_shift  <= r_hold;
                            r_bitCnt <= BIT_W'(DATA_W);
                            r_state  <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (SclFall) begin
                            if (r_bitCnt != '0) begin
                                r_sdaOe  <= 1'b1;
                                r_sdaOut <= r_shift[DATA_W-1];
                                r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
                                r_bitCnt <= r_bitCnt - 1'b1;
                            end else begin
                                r_sdaOe  <= 1'b0;
                                r_sdaOut <= 1'b1;
                                r_state  <= S_ACK_WAIT;
                            end
                        end
                    end
                    S_ACK_WAIT: begin
                        if (SclRise && !SclFall) begin
                            if (!SDAIn) begin
                                r_byteDone <= 1'b1;
                                if (r_remaining != '0) begin
                                    r_remaining <= r_remaining - 1'b1;
                                end
                                if (r_remaining <= CNT_W'(1)) begin
                                    r_txDone <= 1'b1;
                                    r_state  <= S_DONE;
                                end else begin
                                    r_state <= S_LOAD;
                                end
                            end else begin
                                r_nackErr <= 1'b1;
                                r_txDone  <= 1'b1;
                                r_state   <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_sdaOe <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
